// File: rtl/fp32_mul_pkg.sv
// fp32_mul_pkg: shared types and constants for the FP32 multiplier pack stage.
package fp32_mul_pkg;
  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;
  localparam logic [7:0]  EXP_MAX   = 8'hFF;
  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
  typedef struct packed {
    logic       sign;
    fp_class_e  a_cls;
    fp_class_e  b_cls;
    logic [9:0] e;
    logic [22:0] frac;
  } s1_t;
endpackage

// File: rtl/fp32_classify.sv
// fp32_classify: maps a raw exponent and fraction-nonzero flag to an operand class.
module fp32_classify
  import fp32_mul_pkg::*;
(
  input  logic [7:0] exp_raw,
  input  logic       frac_nz,
  output fp_class_e  cls
);
  always_comb cls = (exp_raw == 8'd0) ? FP_ZERO :
                    (exp_raw == EXP_MAX) ? (frac_nz ? FP_NAN : FP_INF) : FP_NORM;
endmodule

// File: rtl/fp32_mul_pack.sv
// fp32_mul_pack: two-stage pack of the FP32 product with specials, handshake and sticky flags.
module fp32_mul_pack
  import fp32_mul_pkg::*;
#(
  parameter int          EXP_BIAS = 127,
  parameter logic [31:0] QNAN     = FP32_QNAN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        a_sign,
  input  logic        b_sign,
  input  logic [7:0]  a_exp,
  input  logic [7:0]  b_exp,
  input  logic        a_frac_nz,
  input  logic        b_frac_nz,
  input  logic [23:0] man_rounded,
  input  logic        exponent_add,
  input  logic        exp_add_from_rnd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_ovf,
  output logic        flag_unf,
  output logic        flag_inv,
  input  logic        flags_clr
);
  fp_class_e a_cls, b_cls;
  s1_t s1_new, s1_d, s1_q;
  logic s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q;
  logic [31:0] result_d, result_q, pack;
  logic [2:0] ev_d, ev_q, pev, flags_d, flags_q;
  logic s1_adv, fire, nan_c, inf_c, zero_c, ovf_c, unf_c;
  logic signed [9:0] e_s;

  fp32_classify u_cls_a (.exp_raw(a_exp), .frac_nz(a_frac_nz), .cls(a_cls));
  fp32_classify u_cls_b (.exp_raw(b_exp), .frac_nz(b_frac_nz), .cls(b_cls));

  // Exponent sum kept 10-bit two's complement so 255+255 cannot wrap.
  always_comb begin
    s1_adv        = !s2_valid_q || out_ready;
    in_ready      = !s1_valid_q || s1_adv;
    fire          = s2_valid_q && out_ready;
    s1_new.sign   = a_sign ^ b_sign;
    s1_new.a_cls  = a_cls;
    s1_new.b_cls  = b_cls;
    s1_new.e      = {2'b0, a_exp} + {2'b0, b_exp} - 10'(EXP_BIAS)
                  + {9'b0, exponent_add} + {9'b0, exp_add_from_rnd};
    s1_new.frac   = exp_add_from_rnd ? 23'd0 : man_rounded[22:0];
    s1_valid_d    = in_ready ? in_valid : s1_valid_q;
    s1_d          = (in_ready && in_valid) ? s1_new : s1_q;
    e_s           = s1_q.e;
    nan_c  = s1_q.a_cls == FP_NAN || s1_q.b_cls == FP_NAN ||
             (s1_q.a_cls == FP_INF && s1_q.b_cls == FP_ZERO) ||
             (s1_q.a_cls == FP_ZERO && s1_q.b_cls == FP_INF);
    inf_c  = s1_q.a_cls == FP_INF || s1_q.b_cls == FP_INF;
    zero_c = s1_q.a_cls == FP_ZERO || s1_q.b_cls == FP_ZERO;
    ovf_c  = e_s >= 10'sd255;
    unf_c  = e_s <= 10'sd0;
    pack   = nan_c  ? QNAN :
             inf_c  ? {s1_q.sign, EXP_MAX, 23'd0} :
             zero_c ? {s1_q.sign, 31'd0} :
             ovf_c  ? {s1_q.sign, EXP_MAX, 23'd0} :
             unf_c  ? {s1_q.sign, 31'd0} :
                      {s1_q.sign, s1_q.e[7:0], s1_q.frac};
    pev    = nan_c ? 3'b001 : (inf_c || zero_c) ? 3'b000 :
             ovf_c ? 3'b100 : unf_c ? 3'b010 : 3'b000;
    s2_valid_d = s1_adv ? s1_valid_q : s2_valid_q;
    result_d   = (s1_adv && s1_valid_q) ? pack : result_q;
    ev_d       = (s1_adv && s1_valid_q) ? pev : ev_q;
    flags_d    = (flags_q & {3{!flags_clr}}) | (fire ? ev_q : 3'b000);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      result_q   <= '0;
      ev_q       <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      result_q   <= result_d;
      ev_q       <= ev_d;
      flags_q    <= flags_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign {flag_ovf, flag_unf, flag_inv} = flags_q;
endmodule

// File: tb/tb_fp32_mul_pack.sv
// tb_fp32_mul_pack: scoreboard bench for the FP32 multiplier pack stage.
module tb_fp32_mul_pack;
  logic clk = 0, rst = 1, in_valid = 0, in_ready;
  logic a_sign = 0, b_sign = 0, a_frac_nz = 0, b_frac_nz = 0;
  logic [7:0] a_exp = 0, b_exp = 0;
  logic [23:0] man_rounded = 0;
  logic exponent_add = 0, exp_add_from_rnd = 0;
  logic out_valid, out_ready = 1, flags_clr = 0;
  logic [31:0] result;
  logic flag_ovf, flag_unf, flag_inv;
  int checks = 0, failures = 0, accepts = 0;
  logic [34:0] sb[$];
  logic [2:0] fl_m = 0;
  logic prev_stall = 0;
  logic [31:0] prev_res = 0;

  fp32_mul_pack dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_sign(a_sign), .b_sign(b_sign), .a_exp(a_exp), .b_exp(b_exp),
    .a_frac_nz(a_frac_nz), .b_frac_nz(b_frac_nz), .man_rounded(man_rounded),
    .exponent_add(exponent_add), .exp_add_from_rnd(exp_add_from_rnd),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inv(flag_inv), .flags_clr(flags_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cls(input logic [7:0] e, input logic nz);
    if (e == 0) return 0;
    if (e == 8'hFF) return nz ? 3 : 2;
    return 1;
  endfunction

  // Reference: {result[31:0], ovf, unf, inv}
  function automatic logic [34:0] model(input logic as, bs, input logic [7:0] ae, be,
      input logic anz, bnz, input logic [23:0] man, input logic ea, er);
    int e, ca, cb;
    logic s;
    logic [22:0] f;
    s  = as ^ bs;
    e  = int'(ae) + int'(be) - 127 + int'(ea) + int'(er);
    ca = cls(ae, anz);
    cb = cls(be, bnz);
    f  = er ? 23'd0 : man[22:0];
    if (ca == 3 || cb == 3 || (ca == 2 && cb == 0) || (ca == 0 && cb == 2)) return {32'h7FC00000, 3'b001};
    if (ca == 2 || cb == 2) return {s, 8'hFF, 23'd0, 3'b000};
    if (ca == 0 || cb == 0) return {s, 31'd0, 3'b000};
    if (e >= 255) return {s, 8'hFF, 23'd0, 3'b100};
    if (e <= 0) return {s, 31'd0, 3'b010};
    return {s, e[7:0], f, 3'b000};
  endfunction

  always @(negedge clk) begin
    logic [34:0] x;
    logic [2:0] ev;
    if (!rst) begin
      ev = 0;
      if (prev_stall) chk("hold", result, prev_res);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
        else begin
          x = sb.pop_front();
          chk("result", result, x[34:3]);
          ev = x[2:0];
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(a_sign, b_sign, a_exp, b_exp, a_frac_nz, b_frac_nz,
                           man_rounded, exponent_add, exp_add_from_rnd));
        accepts++;
      end
      chk("flags", {29'd0, flag_ovf, flag_unf, flag_inv}, {29'd0, fl_m});
      fl_m = (flags_clr ? 3'b000 : fl_m) | ev;
      prev_stall = out_valid && !out_ready;
      prev_res = result;
    end
  end

  task automatic set_in(input logic as, bs, input logic [7:0] ae, be,
      input logic anz, bnz, input logic [23:0] man, input logic ea, er);
    a_sign = as; b_sign = bs; a_exp = ae; b_exp = be; a_frac_nz = anz; b_frac_nz = bnz;
    man_rounded = man; exponent_add = ea; exp_add_from_rnd = er;
  endtask

  task automatic send(input logic as, bs, input logic [7:0] ae, be,
      input logic anz, bnz, input logic [23:0] man, input logic ea, er);
    bit done = 0;
    set_in(as, bs, ae, be, anz, bnz, man, ea, er);
    in_valid = 1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (!out_valid) chk("wait_out_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {29'd0, flag_ovf, flag_unf, flag_inv}, 32'd0);
    rst = 0;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    // 2.0 * 3.0 with latency measured from the drive cycle
    set_in(0, 0, 8'd128, 8'd128, 0, 1, 24'hC00000, 0, 0);
    in_valid = 1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) in_valid = 0;
    end while (!out_valid && n < 10);
    chk("latency", 32'(n), 32'd2);
    chk("mul_2x3", result, 32'h40C00000);
    drain();
    send(0, 0, 8'd127, 8'd127, 0, 0, 24'h000000, 1, 1);
    wait_out();
    chk("rnd_carry", result, 32'h40800000);
    drain();
    send(0, 1, 8'd255, 8'd0, 0, 0, 24'h800000, 0, 0);
    wait_out();
    chk("inf_x_zero", result, 32'h7FC00000);
    drain();
    chk("flag_inv", 32'(flag_inv), 32'd1);
    send(0, 0, 8'd255, 8'd100, 1, 0, 24'h800000, 0, 0);
    wait_out();
    chk("nan_op", result, 32'h7FC00000);
    drain();
    send(1, 0, 8'd255, 8'd130, 0, 1, 24'h900000, 0, 0);
    wait_out();
    chk("neg_inf", result, 32'hFF800000);
    drain();
    send(0, 0, 8'd254, 8'd254, 0, 0, 24'h800000, 0, 0);
    wait_out();
    chk("ovf_res", result, 32'h7F800000);
    drain();
    chk("flag_ovf", 32'(flag_ovf), 32'd1);
    send(1, 0, 8'd10, 8'd10, 0, 0, 24'h800000, 0, 0);
    wait_out();
    chk("unf_res", result, 32'h80000000);
    drain();
    chk("flag_unf", 32'(flag_unf), 32'd1);
    flags_clr = 1;
    @(posedge clk); #1;
    flags_clr = 0;
    chk("clr_all", {29'd0, flag_ovf, flag_unf, flag_inv}, 32'd0);
    // Clear coinciding with a new overflow: set must win
    send(0, 0, 8'd200, 8'd200, 0, 0, 24'h800000, 0, 0);
    wait_out();
    flags_clr = 1;
    @(posedge clk); #1;
    flags_clr = 0;
    chk("ovf_set_wins", 32'(flag_ovf), 32'd1);
    drain();
    // Backpressure: 5 bundles with out_ready low for 4 cycles
    out_ready = 0;
    acc0 = accepts;
    fork
      for (int i = 0; i < 5; i++)
        send(logic'(i[0]), 0, 8'(100 + i), 8'(60 + 3 * i), 0, 0, 24'h800000 | 24'(i * 4099), 0, 0);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_accepts", 32'(accepts - acc0), 32'd2);
        @(posedge clk); #1;
        out_ready = 1;
      end
    join
    drain();
    chk("bp_drained", 32'(sb.size()), 32'd0);
    chk("bp_count", 32'(accepts - acc0), 32'd5);
    // Reset with both stages full
    out_ready = 0;
    send(0, 0, 8'd130, 8'd120, 0, 0, 24'hA00000, 0, 0);
    send(0, 0, 8'd131, 8'd121, 0, 0, 24'hB00000, 0, 0);
    chk("full_valid", 32'(out_valid), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("pre_rst_ovf", 32'(flag_ovf), 32'd1);
    rst = 1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_flags", {29'd0, flag_ovf, flag_unf, flag_inv}, 32'd0);
    sb.delete();
    fl_m = 0;
    prev_stall = 0;
    out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(out_valid), 32'd0);
    send(0, 0, 8'd128, 8'd128, 0, 0, 24'hC00000, 0, 0);
    wait_out();
    chk("post_rst_mul", result, 32'h40C00000);
    drain();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
